// File: rtl/fir_pkg.sv
// Shared FIR definitions: quantiser mode encoding and symmetric output bounds.
package fir_pkg;

  typedef enum logic [1:0] {
    FIR_Q_WRAP     = 2'd0,
    FIR_Q_SAT      = 2'd1,
    FIR_Q_RND_HU   = 2'd2,
    FIR_Q_RND_CONV = 2'd3
  } fir_qmode_t;

  // Bounds are symmetric, so the most negative code is never produced by clipping.
  function automatic int fir_qmax(input int owidth);
    return (1 << (owidth - 1)) - 1;
  endfunction

  function automatic int fir_qmin(input int owidth);
    return -fir_qmax(owidth);
  endfunction

endpackage

// File: rtl/fir_quant_lane.sv
// One channel of the output quantiser: stage 1 rounds and scales, stage 2
// detects out-of-range values and clips or wraps.
module fir_quant_lane
  import fir_pkg::*;
#(
  parameter int IWIDTH = 24,
  parameter int OWIDTH = 16,
  parameter int SHIFT  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              s1_en_i,
  input  logic              s2_en_i,
  input  logic [1:0]        s1_mode_i,
  input  logic [1:0]        s2_mode_i,
  input  logic [IWIDTH-1:0] x_i,
  output logic [OWIDTH-1:0] data_o,
  output logic              sat_o
);

  localparam int QW = IWIDTH + 1 - SHIFT;
  localparam logic signed [QW-1:0] QMAX = QW'(fir_qmax(OWIDTH));
  localparam logic signed [QW-1:0] QMIN = QW'(fir_qmin(OWIDTH));
  localparam logic [IWIDTH:0] ONE  = (IWIDTH + 1)'(1);
  localparam logic [IWIDTH:0] HALF = ONE << (SHIFT - 1);

  logic [IWIDTH:0]        k;
  logic [IWIDTH:0]        r;
  logic [SHIFT-1:0]       r_frac_unused;
  logic signed [QW-1:0]   q_next;
  logic signed [QW-1:0]   q1;
  logic                   sat_next;
  logic [OWIDTH-1:0]      data_next;

  // One extra bit of headroom keeps x + k from overflowing; the arithmetic
  // shift then reduces to taking the upper bits of r.
  always_comb begin
    k = '0;
    case (fir_qmode_t'(s1_mode_i))
      FIR_Q_RND_HU:   k = HALF;
      FIR_Q_RND_CONV: k = HALF - ONE + {{IWIDTH{1'b0}}, x_i[SHIFT]};
      default:        k = '0;
    endcase
    r = {x_i[IWIDTH-1], x_i} + k;
    {q_next, r_frac_unused} = r;
  end

  always_comb begin
    sat_next  = (q1 > QMAX) || (q1 < QMIN);
    data_next = q1[OWIDTH-1:0];
    if (fir_qmode_t'(s2_mode_i) != FIR_Q_WRAP && sat_next)
      data_next = (q1 > QMAX) ? QMAX[OWIDTH-1:0] : QMIN[OWIDTH-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q1     <= '0;
      data_o <= '0;
      sat_o  <= 1'b0;
    end else begin
      if (s1_en_i) q1 <= q_next;
      if (s2_en_i) begin
        data_o <= data_next;
        sat_o  <= sat_next;
      end
    end
  end

endmodule

// File: rtl/fir_out_quantizer.sv
// Multi-channel two-stage output quantiser with valid/ready handshakes and a
// saturating count of out-of-range output beats.
module fir_out_quantizer
  import fir_pkg::*;
#(
  parameter int IWIDTH    = 24,
  parameter int OWIDTH    = 16,
  parameter int SHIFT     = 8,
  parameter int CHANNELS  = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [1:0]                   mode_i,
  input  logic                         s_valid_i,
  output logic                         s_ready_o,
  input  logic [CHANNELS*IWIDTH-1:0]   s_data_i,
  output logic                         m_valid_o,
  input  logic                         m_ready_i,
  output logic [CHANNELS*OWIDTH-1:0]   m_data_o,
  output logic [CHANNELS-1:0]          m_sat_o,
  input  logic                         sat_cnt_clr_i,
  output logic [CNT_WIDTH-1:0]         sat_cnt_o
);

  logic       v1;
  logic       load2;
  logic       accept;
  logic       s2_en;
  logic       sat_hs;
  fir_qmode_t mode1;

  // Ready ripples back combinationally from the sink so a full pipeline
  // still moves one beat per clock.
  assign load2     = !m_valid_o || m_ready_i;
  assign s_ready_o = !v1 || load2;
  assign accept    = s_valid_i && s_ready_o;
  assign s2_en     = load2 && v1;
  assign sat_hs    = m_valid_o && m_ready_i && (|m_sat_o);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v1        <= 1'b0;
      m_valid_o <= 1'b0;
      mode1     <= FIR_Q_WRAP;
    end else begin
      if (s_ready_o) v1 <= s_valid_i;
      if (load2) m_valid_o <= v1;
      if (accept) mode1 <= fir_qmode_t'(mode_i);
    end
  end

  // Clear wins over a simultaneous increment; the count sticks at all-ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      sat_cnt_o <= '0;
    else if (sat_cnt_clr_i)
      sat_cnt_o <= '0;
    else if (sat_hs && sat_cnt_o != '1)
      sat_cnt_o <= sat_cnt_o + CNT_WIDTH'(1);
  end

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_lane
    fir_quant_lane #(
      .IWIDTH(IWIDTH),
      .OWIDTH(OWIDTH),
      .SHIFT (SHIFT)
    ) u_lane (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .s1_en_i  (accept),
      .s2_en_i  (s2_en),
      .s1_mode_i(mode_i),
      .s2_mode_i(mode1),
      .x_i      (s_data_i[ch*IWIDTH +: IWIDTH]),
      .data_o   (m_data_o[ch*OWIDTH +: OWIDTH]),
      .sat_o    (m_sat_o[ch])
    );
  end

endmodule

// File: tb/tb_fir_out_quantizer.sv
// Directed and randomised checks of fir_out_quantizer with two lanes, plus a
// second instance with a 2-bit counter to exercise counter saturation.
module tb_fir_out_quantizer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        s_valid;
  logic [47:0] s_data;
  logic        m_ready;
  logic        clr;

  logic        s_ready, m_valid;
  logic [31:0] m_data;
  logic [1:0]  m_sat;
  logic [15:0] sat_cnt;

  logic        s_ready_c, m_valid_c;
  logic [31:0] m_data_c;
  logic [1:0]  m_sat_c;
  logic [1:0]  sat_cnt_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fir_out_quantizer #(
    .IWIDTH(24), .OWIDTH(16), .SHIFT(8), .CHANNELS(2), .CNT_WIDTH(16)
  ) dut (
    .clk_i(clk), .rst_i(rst), .mode_i(mode),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data),
    .m_sat_o(m_sat), .sat_cnt_clr_i(clr), .sat_cnt_o(sat_cnt)
  );

  fir_out_quantizer #(
    .IWIDTH(24), .OWIDTH(16), .SHIFT(8), .CHANNELS(2), .CNT_WIDTH(2)
  ) dut_c (
    .clk_i(clk), .rst_i(rst), .mode_i(mode),
    .s_valid_i(s_valid), .s_ready_o(s_ready_c), .s_data_i(s_data),
    .m_valid_o(m_valid_c), .m_ready_i(m_ready), .m_data_o(m_data_c),
    .m_sat_o(m_sat_c), .sat_cnt_clr_i(clr), .sat_cnt_o(sat_cnt_c)
  );

  // Reference: floor division with explicit remainder handling for rounding.
  function automatic logic [16:0] model(input logic [1:0] md, input logic [23:0] x);
    longint xv, fl, rem;
    logic s;
    logic [15:0] d;
    xv = longint'($signed(x));
    if (xv >= 0) fl = xv / 256;
    else fl = -((-xv + 255) / 256);
    rem = xv - fl * 256;
    if (md == 2'd2 && rem >= 128) fl = fl + 1;
    if (md == 2'd3 && (rem > 128 || (rem == 128 && fl[0]))) fl = fl + 1;
    s = (fl > 32767) || (fl < -32767);
    if (md != 2'd0 && s) d = (fl > 0) ? 16'h7FFF : 16'h8001;
    else d = fl[15:0];
    return {s, d};
  endfunction

  task automatic send_beat(input logic [1:0] md, input logic [23:0] d0, input logic [23:0] d1,
                           input logic clr_out, output logic [31:0] data,
                           output logic [1:0] sat, output int lat);
    mode = md; s_data = {d1, d0}; s_valid = 1'b1; m_ready = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    lat = 1;
    while (!m_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    data = m_data;
    sat  = m_sat;
    clr  = clr_out;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic pulse_clear();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_s_ready got %b want 1", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_valid got %b want 0", m_valid); end
    checks++; if (m_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_m_data got %h want 0", m_data); end
    checks++; if (m_sat !== 2'b00) begin errors++; $display("[TB] FAIL reset_m_sat got %b want 00", m_sat); end
    checks++; if (sat_cnt !== 16'h0) begin errors++; $display("[TB] FAIL reset_sat_cnt got %h want 0", sat_cnt); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_rounding();
    logic [15:0] e0 [4] = '{16'd1, 16'd1, 16'd2, 16'd2};
    logic [15:0] e1 [4] = '{16'd2, 16'd2, 16'd3, 16'd2};
    logic [31:0] d;
    logic [1:0]  s;
    int          lat;
    for (int m = 0; m < 4; m++) begin
      send_beat(2'(m), 24'h000180, 24'h000280, 1'b0, d, s, lat);
      checks++; if (lat != 2) begin errors++; $display("[TB] FAIL round_latency mode %0d got %0d want 2", m, lat); end
      checks++; if (d !== {e1[m], e0[m]}) begin errors++; $display("[TB] FAIL round_data mode %0d got %h want %h", m, d, {e1[m], e0[m]}); end
      checks++; if (s !== 2'b00) begin errors++; $display("[TB] FAIL round_sat mode %0d got %b want 00", m, s); end
    end
  endtask

  task automatic test_negative();
    logic [15:0] e0 [4] = '{16'hFFFE, 16'hFFFE, 16'hFFFF, 16'hFFFE};
    logic [15:0] e1 [4] = '{16'h0000, 16'h0000, 16'h0001, 16'h0000};
    logic [31:0] d;
    logic [1:0]  s;
    int          lat;
    for (int m = 0; m < 4; m++) begin
      send_beat(2'(m), 24'hFFFE80, 24'h000080, 1'b0, d, s, lat);
      checks++; if (d !== {e1[m], e0[m]}) begin errors++; $display("[TB] FAIL neg_data mode %0d got %h want %h", m, d, {e1[m], e0[m]}); end
      checks++; if (s !== 2'b00) begin errors++; $display("[TB] FAIL neg_sat mode %0d got %b want 00", m, s); end
    end
  endtask

  task automatic test_saturation();
    logic [1:0]  md [5] = '{2'd2, 2'd1, 2'd0, 2'd3, 2'd1};
    logic [23:0] x0 [5] = '{24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFF00};
    logic [23:0] x1 [5] = '{24'h800000, 24'h800000, 24'h800000, 24'h800000, 24'h800100};
    logic [31:0] ed [5] = '{32'h8001_7FFF, 32'h8001_7FFF, 32'h8000_7FFF, 32'h8001_7FFF, 32'h8001_7FFF};
    logic [1:0]  es [5] = '{2'b11, 2'b10, 2'b10, 2'b11, 2'b00};
    logic [31:0] d;
    logic [1:0]  s;
    int          lat;
    int          exp_cnt = 0;
    pulse_clear();
    for (int i = 0; i < 5; i++) begin
      send_beat(md[i], x0[i], x1[i], 1'b0, d, s, lat);
      if (es[i] != 2'b00) exp_cnt++;
      checks++; if (d !== ed[i]) begin errors++; $display("[TB] FAIL sat_data vec %0d got %h want %h", i, d, ed[i]); end
      checks++; if (s !== es[i]) begin errors++; $display("[TB] FAIL sat_flag vec %0d got %b want %b", i, s, es[i]); end
      checks++; if (sat_cnt !== 16'(exp_cnt)) begin errors++; $display("[TB] FAIL sat_count vec %0d got %0d want %0d", i, sat_cnt, exp_cnt); end
    end
  endtask

  task automatic test_cnt_saturate();
    logic [31:0] d;
    logic [1:0]  s;
    int          lat;
    pulse_clear();
    checks++; if (sat_cnt_c !== 2'd0) begin errors++; $display("[TB] FAIL cnt2_clear got %0d want 0", sat_cnt_c); end
    for (int i = 1; i <= 5; i++) begin
      send_beat(2'd2, 24'h7FFFFF, 24'h000000, 1'b0, d, s, lat);
      checks++; if (sat_cnt_c !== 2'((i > 3) ? 3 : i)) begin errors++; $display("[TB] FAIL cnt2_hold beat %0d got %0d want %0d", i, sat_cnt_c, (i > 3) ? 3 : i); end
    end
    checks++; if (sat_cnt !== 16'd5) begin errors++; $display("[TB] FAIL cnt16_five got %0d want 5", sat_cnt); end
  endtask

  task automatic test_clr_priority();
    logic [31:0] d;
    logic [1:0]  s;
    int          lat;
    send_beat(2'd1, 24'h800000, 24'h7FFFFF, 1'b1, d, s, lat);
    checks++; if (s !== 2'b01) begin errors++; $display("[TB] FAIL clr_beat_sat got %b want 01", s); end
    checks++; if (sat_cnt_c !== 2'd0) begin errors++; $display("[TB] FAIL clr_priority_c got %0d want 0", sat_cnt_c); end
    checks++; if (sat_cnt !== 16'd0) begin errors++; $display("[TB] FAIL clr_priority got %0d want 0", sat_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] vals [6] = '{24'h000180, 24'h000280, 24'hFFFE80, 24'h7FFFFF, 24'h800000, 24'h012345};
    logic [31:0] exp_d [6];
    logic [16:0] r0, r1;
    for (int i = 0; i < 6; i++) begin
      r0 = model(2'(i % 4), vals[i]);
      r1 = model(2'(i % 4), vals[5 - i]);
      exp_d[i] = {r1[15:0], r0[15:0]};
    end
    m_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c >= 2 && c < 8) begin
        checks++; if (m_valid !== 1'b1 || m_data !== exp_d[c - 2]) begin errors++; $display("[TB] FAIL b2b_out cycle %0d got v=%b %h want v=1 %h", c, m_valid, m_data, exp_d[c - 2]); end
      end else begin
        checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle cycle %0d got v=%b want 0", c, m_valid); end
      end
      if (c < 6) begin
        checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready cycle %0d got %b want 1", c, s_ready); end
        mode = 2'(c % 4); s_data = {vals[5 - c], vals[c]}; s_valid = 1'b1;
      end else begin
        s_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random_stream();
    localparam int N = 150;
    logic [33:0] sb [$];
    logic [33:0] exp_v, prev;
    logic [16:0] r0, r1;
    logic [23:0] d0, d1;
    logic        stall_prev = 1'b0;
    logic        accepted = 1'b0;
    int          sent = 0, recv = 0;
    s_valid = 1'b0;
    prev = '0;
    for (int cyc = 0; cyc < 4000 && recv < N; cyc++) begin
      m_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (stall_prev) begin
        checks++; if (m_valid !== 1'b1 || {m_sat, m_data} !== prev) begin errors++; $display("[TB] FAIL stall_hold cycle %0d got v=%b %h want v=1 %h", cyc, m_valid, {m_sat, m_data}, prev); end
      end
      accepted = s_valid && s_ready;
      if (accepted) begin
        r0 = model(mode, s_data[23:0]);
        r1 = model(mode, s_data[47:24]);
        sb.push_back({r1[16], r0[16], r1[15:0], r0[15:0]});
        sent++;
      end
      if (m_valid && m_ready) begin
        recv++;
        if (sb.size() == 0) begin
          checks++; errors++; $display("[TB] FAIL stream_extra got %h want none", {m_sat, m_data});
        end else begin
          exp_v = sb.pop_front();
          checks++; if ({m_sat, m_data} !== exp_v) begin errors++; $display("[TB] FAIL stream_beat %0d got %h want %h", recv, {m_sat, m_data}, exp_v); end
        end
      end
      stall_prev = m_valid && !m_ready;
      prev = {m_sat, m_data};
      @(posedge clk); #1;
      if (accepted || !s_valid) begin
        if (sent < N && $urandom_range(0, 3) != 0) begin
          case ($urandom_range(0, 5))
            0: d0 = 24'h7FFFFF;
            1: d0 = 24'h800000;
            2: d0 = 24'h7FFF80;
            default: d0 = 24'($urandom);
          endcase
          case ($urandom_range(0, 5))
            0: d1 = 24'h800080;
            1: d1 = 24'h000280;
            default: d1 = 24'($urandom);
          endcase
          mode = 2'($urandom_range(0, 3));
          s_data = {d1, d0};
          s_valid = 1'b1;
        end else begin
          s_valid = 1'b0;
        end
      end
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    checks++; if (recv != N || sb.size() != 0) begin errors++; $display("[TB] FAIL stream_count got %0d beats want %0d", recv, N); end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_midstream_reset();
    int stale = 0;
    m_ready = 1'b1;
    mode = 2'd2;
    s_data = {24'h800000, 24'h7FFFFF};
    s_valid = 1'b1;
    @(posedge clk); #1;
    s_data = {24'h000280, 24'h000180};
    @(posedge clk); #1;
    s_valid = 1'b0;
    checks++; if (m_valid !== 1'b1) begin errors++; $display("[TB] FAIL inflight_valid got %b want 1", m_valid); end
    rst = 1'b1;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_valid got %b want 0", m_valid); end
    checks++; if (m_data !== 32'h0) begin errors++; $display("[TB] FAIL rst_mid_data got %h want 0", m_data); end
    checks++; if (m_sat !== 2'b00) begin errors++; $display("[TB] FAIL rst_mid_sat got %b want 00", m_sat); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_ready got %b want 1", s_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (m_valid) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("[TB] FAIL rst_stale got %0d beats want 0", stale); end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; s_valid = 1'b0; m_ready = 1'b0; mode = 2'd0; s_data = '0;
    test_reset();
    test_rounding();
    test_negative();
    test_saturation();
    test_cnt_saturate();
    test_clr_priority();
    test_back_to_back();
    test_random_stream();
    test_midstream_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_out_quantizer.md
# fir_out_quantizer

Multi-channel, pipelined output quantiser for the FIR accumulator path. It sits between the MAC/accumulator and the sample sink, and uses valid/ready handshakes on both sides. It scales the wide accumulator by dropping LSBs, then applies a run-time selectable mode: wrap, truncate-saturate, round-half-up or convergent rounding. Saturation events are flagged per sample and accumulated in a clearable counter.

## Interface
- IWIDTH, 24: accumulator width per channel.
- OWIDTH, 16: output sample width per channel. Legal range: 2 ≤ OWIDTH ≤ IWIDTH−SHIFT.
- SHIFT, 8: number of LSBs dropped. Legal range: SHIFT ≥ 1.
- CHANNELS, 1: number of parallel lanes, all sharing one handshake.
- CNT_WIDTH, 16: width of the saturation-event counter.
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- mode_i  in  2  quantisation mode: 0 WRAP, 1 SAT, 2 RND_HU, 3 RND_CONV. Sampled with each accepted input beat.
- s_valid_i  in  1  input beat valid.
- s_ready_o  out  1  input beat accepted when s_valid_i && s_ready_o.
- s_data_i  in  CHANNELS*IWIDTH  signed accumulators; channel 0 occupies the LSBs.
- m_valid_o  out  1  output beat valid.
- m_ready_i  in  1  sink ready.
- m_data_o  out  CHANNELS*OWIDTH  signed quantised samples.
- m_sat_o  out  CHANNELS  per-lane out-of-range flag for the current output beat.
- sat_cnt_clr_i  in  1  synchronous clear of sat_cnt_o.
- sat_cnt_o  out  CNT_WIDTH  count of output beats with any m_sat_o bit set.

## Operation
- Bounds are symmetric: MAX = 2^(OWIDTH−1)−1 and MIN = −MAX. The code −2^(OWIDTH−1) is never produced by a saturating mode.
- Stage 1 computes r = x + k in IWIDTH+1 bits, so the add cannot overflow. The rounding constant k depends on mode:
  - WRAP and SAT: k = 0.
  - RND_HU: k = 2^(SHIFT−1).
  - RND_CONV: k = 2^(SHIFT−1) − 1 + x[SHIFT], which rounds ties to even.
- Stage 1 then forms q = r >>> SHIFT, an arithmetic shift, and carries q and the mode forward.
- Stage 2 sets the flag sat = (q > MAX) || (q < MIN) in every mode, WRAP included.
- Stage 2 output:
  - WRAP: output is q[OWIDTH−1:0].
  - SAT, RND_HU, RND_CONV: output clips to MAX or MIN when out of range, otherwise q[OWIDTH−1:0].
- Lanes are fully independent. Only the handshake is shared.
- Counter behaviour:
  - sat_cnt_o increments by 1 on each output handshake (m_valid_o && m_ready_i) where |m_sat_o is set.
  - It holds at all-ones and never wraps.
  - sat_cnt_clr_i takes priority: if clear and increment occur in the same cycle, the result is 0.
- Changing mode_i mid-stream is legal. Each beat uses the mode captured at its own acceptance.

## Timing
- Two register stages. With m_ready_i held high, latency is 2 cycles from input handshake to m_valid_o, at one beat per clock.
- Backpressure:
  - Stage 2 loads when !m_valid_o || m_ready_i.
  - Stage 1 loads when stage 1 is empty or stage 2 is loading.
  - s_ready_o = !v1 || stage-2 load. This is combinational from m_ready_i, so the pipeline has no bubbles.
- While m_valid_o && !m_ready_i, m_data_o and m_sat_o must hold stable.
- No beat is ever dropped or duplicated.
- Reset values:
  - m_valid_o = 0, m_data_o = 0, m_sat_o = 0, sat_cnt_o = 0.
  - Internal valids are 0, so s_ready_o = 1 during reset (pipeline empty).
- Reset asserted mid-stream discards all in-flight beats immediately.
- Pipeline full with m_ready_i low: s_ready_o = 0, and s_data_i is ignored.

## Structure
- Shared package fir_pkg provides:
  - the typedef enum logic [1:0] fir_qmode_t: FIR_Q_WRAP, FIR_Q_SAT, FIR_Q_RND_HU, FIR_Q_RND_CONV;
  - constant functions fir_qmax(OWIDTH) and fir_qmin(OWIDTH).
- Sub-module fir_quant_lane holds the per-channel stage-1 and stage-2 arithmetic with enable inputs. It is instantiated CHANNELS times by a generate loop.
- The top level owns the valid/ready control, the mode pipeline register and the counter.

## Test plan
The bench uses IWIDTH=24, OWIDTH=16, SHIFT=8, CHANNELS=2 unless stated.
- Input 0x000180 (1.5): WRAP → 1, SAT → 1, RND_HU → 2, RND_CONV → 2. Input 0x000280 (2.5): RND_HU → 3, RND_CONV → 2.
- Input 0xFFFE80 (−1.5): SAT → −2 (0xFFFE), RND_HU → −1 (0xFFFF), RND_CONV → −2. No flags set.
- Input 0x7FFFFF in RND_HU → 0x7FFF with m_sat_o set. Input 0x800000 in SAT → 0x8001 with flag; in WRAP → 0x8000 with flag. sat_cnt_o increments by 1 per beat, not per lane.
- Random stream with random m_ready_i stalls: every output matches the reference model in order. Outputs stay stable during stalls. The full-speed run shows latency 2 and 1 beat per clock.
- CNT_WIDTH=2:
  - Five saturating beats → sat_cnt_o holds at 3.
  - sat_cnt_clr_i pulsed together with a saturating handshake → 0.
- Assert rst_i while 2 beats are in flight: all outputs read 0, and after release no stale beat appears.
